// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
// MAX_HOLD_DEF exists only when RR_ARB_TIMEOUT_EN is defined.
package rr_arb_pkg;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned MAX_HOLD_DEF = 8;
`endif

    typedef enum logic {IDLE, GRANT} state_e;
endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// timeout_pulse is present only when RR_ARB_TIMEOUT_EN is defined.
interface rr_arbiter_4_if;
    import rr_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [ID_W-1:0]    gnt_id;
    logic               rel_pulse;
`ifdef RR_ARB_TIMEOUT_EN
    logic               timeout_pulse;
`endif

    modport master (
        output req,
        input  gnt, gnt_valid, gnt_id, rel_pulse
`ifdef RR_ARB_TIMEOUT_EN
        , input timeout_pulse
`endif
    );

    modport slave (
        input  req,
        output gnt, gnt_valid, gnt_id, rel_pulse
`ifdef RR_ARB_TIMEOUT_EN
        , output timeout_pulse
`endif
    );
endinterface

// File: rtl/rr_arbiter_4_pick4.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping mod 4.
module rr_pick4
    import rr_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_o
);
    logic [ID_W-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit is the last to win.
    always_comb begin
        winner_o = ptr_i;
        any_o    = 1'b0;
        idx      = ptr_i;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr_i + ID_W'(i);
            if (req_i[idx]) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter: grant held while the owner requests, no preemption.
// Define RR_ARB_TIMEOUT_EN to add the MAX_HOLD forced release and timeout_pulse.
module rr_arbiter_4
    import rr_arb_pkg::*;
`ifdef RR_ARB_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
    input  logic           clk,
    input  logic           reset,
    rr_arbiter_4_if.slave  bus
);
    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [NUM_REQ-1:0] gnt_q;
    logic               gnt_valid_q;
    logic [ID_W-1:0]    gnt_id_q;
    logic               rel_q;
    logic [ID_W-1:0]    winner;
    logic               any;
`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0]         hold_cnt_q;
    logic               timeout_q;
`endif

    rr_pick4 u_pick (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any)
    );

    // The owner just served drops to lowest priority.
    assign ptr_d = gnt_id_q + ID_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            rel_q       <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            rel_q <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (any) begin
                        gnt_q       <= NUM_REQ'(1) << winner;
                        gnt_id_q    <= winner;
                        gnt_valid_q <= 1'b1;
                        state_q     <= GRANT;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt_q  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!bus.req[gnt_id_q]) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        rel_q       <= 1'b1;
                        ptr_q       <= ptr_d;
                        state_q     <= IDLE;
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else if (hold_cnt_q == HOLD_LAST) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        rel_q       <= 1'b1;
                        timeout_q   <= 1'b1;
                        ptr_q       <= ptr_d;
                        state_q     <= IDLE;
                    end else begin
                        hold_cnt_q  <= hold_cnt_q + 8'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.rel_pulse = rel_q;
`ifdef RR_ARB_TIMEOUT_EN
    assign bus.timeout_pulse = timeout_q;
`endif
endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4; the forced-release steps run only with RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_4;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    rr_arbiter_4_if bus ();

    rr_arbiter_4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] id);
        chk({tag, ".gnt"}, 8'(bus.gnt), 8'(g));
        chk({tag, ".valid"}, 8'(bus.gnt_valid), 8'(1));
        chk({tag, ".id"}, 8'(bus.gnt_id), 8'(id));
        chk({tag, ".rel"}, 8'(bus.rel_pulse), 8'(0));
    endtask

    task automatic chk_release(input string tag);
        chk({tag, ".gnt"}, 8'(bus.gnt), 8'(0));
        chk({tag, ".valid"}, 8'(bus.gnt_valid), 8'(0));
        chk({tag, ".rel"}, 8'(bus.rel_pulse), 8'(1));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.req = 4'b1111;

        // Reset held two cycles with all requests up
        tick();
        tick();
        chk("rst.gnt", 8'(bus.gnt), 8'(0));
        chk("rst.valid", 8'(bus.gnt_valid), 8'(0));
        chk("rst.rel", 8'(bus.rel_pulse), 8'(0));
        chk("rst.ptr", 8'(dut.ptr_q), 8'(0));
        reset = 1'b0;
        tick();
        chk_grant("rst_exit", 4'b0001, 2'd0);

        // Rotation 0,1,2,3,0 with a bubble and rel_pulse between grants
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            chk("rot.hold", 8'(bus.gnt), 8'(4'b0001 << k));
            bus.req = 4'b1111 & ~(4'b0001 << k);
            tick();
            chk_release("rot.rel");
            bus.req = 4'b1111;
            tick();
            chk_grant("rot.next", 4'b0001 << ((k + 1) % 4), 2'((k + 1) % 4));
        end

        // Serve 2 so ptr becomes 3, then 0101 must pick 0
        bus.req = 4'b0100;
        tick();
        chk_release("skip.rel0");
        tick();
        chk_grant("skip.g2", 4'b0100, 2'd2);
        bus.req = 4'b0000;
        tick();
        chk_release("skip.rel2");
        chk("skip.ptr3", 8'(dut.ptr_q), 8'(3));
        bus.req = 4'b0101;
        tick();
        chk_grant("wrap.g0", 4'b0001, 2'd0);
        bus.req = 4'b0100;
        tick();
        chk_release("wrap.rel0");
        chk("wrap.ptr1", 8'(dut.ptr_q), 8'(1));
        bus.req = 4'b0101;
        tick();
        chk_grant("skip.g2b", 4'b0100, 2'd2);

        // No preemption: owner 1 holds while 3 requests
        bus.req = 4'b0010;
        tick();
        chk_release("np.rel2");
        tick();
        chk_grant("np.g1", 4'b0010, 2'd1);
        bus.req = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("np.hold", 8'(bus.gnt), 8'(4'b0010));
        end
        bus.req = 4'b1000;
        tick();
        chk_release("np.rel1");
        tick();
        chk_grant("np.g3", 4'b1000, 2'd3);

        // Reset asserted mid-grant
        bus.req = 4'b0100;
        tick();
        chk_release("mr.rel3");
        tick();
        chk_grant("mr.g2", 4'b0100, 2'd2);
        reset = 1'b1;
        tick();
        chk("mr.gnt", 8'(bus.gnt), 8'(0));
        chk("mr.valid", 8'(bus.gnt_valid), 8'(0));
        chk("mr.rel", 8'(bus.rel_pulse), 8'(0));
        chk("mr.ptr", 8'(dut.ptr_q), 8'(0));
        reset   = 1'b0;
        bus.req = 4'b0110;
        tick();
        chk_grant("mr.g1", 4'b0010, 2'd1);

`ifdef RR_ARB_TIMEOUT_EN
        // Owner 0 never drops: exactly 8 granted cycles, then forced release
        bus.req = 4'b0000;
        tick();
        chk_release("to.rel1");
        chk("to.notimeout", 8'(bus.timeout_pulse), 8'(0));
        tick();
        bus.req = 4'b0011;
        tick();
        chk_grant("to.g0", 4'b0001, 2'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to.hold", 8'(bus.gnt), 8'(4'b0001));
            chk("to.hold_to", 8'(bus.timeout_pulse), 8'(0));
        end
        tick();
        chk_release("to.force");
        chk("to.pulse", 8'(bus.timeout_pulse), 8'(1));
        tick();
        chk_grant("to.g1", 4'b0010, 2'd1);
        chk("to.pulse_end", 8'(bus.timeout_pulse), 8'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
